// File: rtl/uart_tx.sv
// uart_tx: start/busy handshake UART transmitter, LSB-first, optional parity, 1 or 2 stop bits
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clkx16,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam int TW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  logic [2:0]           r_state;
  logic [TW-1:0]        r_tick;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_last;
  assign w_last = r_tick == TW'(OVERSAMPLE - 1);
  assign tx     = r_tx;
  assign busy   = r_busy;
  assign done   = r_done;
  // Frame sequencer: each bit is held for OVERSAMPLE ticks, next bit loaded on the last tick edge
  always_ff @(posedge clkx16) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_shift <= data[DATA_BITS-1:0];
          r_par   <= (^data[DATA_BITS-1:0]) ^ (PARITY == 2);
          r_tx    <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= S_START;
          r_tick  <= '0;
        end
      end else if (!w_last) begin
        r_tick <= r_tick + TW'(1);
      end else begin
        r_tick <= '0;
        case (r_state)
          S_START: begin
            r_tx    <= r_shift[0];
            r_bit   <= '0;
            r_state <= S_DATA;
          end
          S_DATA: begin
            if (r_bit == 3'(DATA_BITS - 1)) begin
              r_bit   <= '0;
              r_tx    <= PARITY != 0 ? r_par : 1'b1;
              r_state <= PARITY != 0 ? S_PARITY : S_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[1];
              r_shift <= r_shift >> 1;
            end
          end
          S_PARITY: begin
            r_tx    <= 1'b1;
            r_bit   <= '0;
            r_state <= S_STOP;
          end
          default: begin
            if (r_bit == 3'(STOP_BITS - 1)) begin
              r_bit   <= '0;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks on 8N1, 8E1, 8O1 and 8N2 transmitters
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data = 8'h00;
  logic [3:0] st = 4'h0;
  logic [3:0] tx_v, busy_v, done_v;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_n1 (
    .clkx16(clk), .reset(reset), .data(data), .start(st[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) u_e1 (
    .clkx16(clk), .reset(reset), .data(data), .start(st[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) u_o1 (
    .clkx16(clk), .reset(reset), .data(data), .start(st[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2)) u_n2 (
    .clkx16(clk), .reset(reset), .data(data), .start(st[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle_chk(input int u, input string tag);
    chk($sformatf("%s_tx%0d", tag, u), tx_v[u], 1'b1);
    chk($sformatf("%s_busy%0d", tag, u), busy_v[u], 1'b0);
    chk($sformatf("%s_done%0d", tag, u), done_v[u], 1'b0);
  endtask

  // Entered at the first negedge after the accept edge; leaves one negedge after the done cycle.
  task automatic body(input int u, input logic [11:0] exp, input int nb, input logic nxt, input string tag);
    chk({tag, "_busy_on"}, busy_v[u], 1'b1);
    chk({tag, "_start_lvl"}, tx_v[u], 1'b0);
    repeat (8) @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      chk($sformatf("%s_bit%0d", tag, k), tx_v[u], exp[k]);
      if (k < nb - 1) repeat (16) @(negedge clk);
    end
    repeat (7) @(negedge clk);
    chk({tag, "_busy_last"}, busy_v[u], 1'b1);
    chk({tag, "_done_early"}, done_v[u], 1'b0);
    @(negedge clk);
    chk({tag, "_busy_off"}, busy_v[u], 1'b0);
    chk({tag, "_done_pulse"}, done_v[u], 1'b1);
    chk({tag, "_tx_idle"}, tx_v[u], 1'b1);
    @(negedge clk);
    chk({tag, "_done_clear"}, done_v[u], 1'b0);
    chk({tag, "_busy_next"}, busy_v[u], nxt);
    chk({tag, "_tx_next"}, tx_v[u], ~nxt);
  endtask

  task automatic send(input int u, input logic [7:0] d, input logic [11:0] exp, input int nb, input string tag);
    data = d;
    st[u] = 1'b1;
    @(negedge clk);
    st[u] = 1'b0;
    data = 8'hXX;
    body(u, exp, nb, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    reset = 1'b1;
    st = 4'hF;
    data = 8'hA5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int u = 0; u < 4; u++) idle_chk(u, $sformatf("rst%0d", c));
    end
    reset = 1'b0;
    st = 4'h0;
    @(negedge clk);
    for (int u = 0; u < 4; u++) idle_chk(u, "rst_rel");

    send(0, 8'h55, {1'b1, 8'h55, 1'b0}, 10, "n1_55");
    send(1, 8'hA7, {1'b1, 1'b1, 8'hA7, 1'b0}, 11, "e1_a7");
    send(2, 8'hA7, {1'b1, 1'b0, 8'hA7, 1'b0}, 11, "o1_a7");

    data = 8'h00;
    st[3] = 1'b1;
    @(negedge clk);
    body(3, {2'b11, 8'h00, 1'b0}, 11, 1'b1, "n2_first");
    st[3] = 1'b0;
    body(3, {2'b11, 8'h00, 1'b0}, 11, 1'b0, "n2_second");

    data = 8'h0F;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    fork
      begin
        repeat (40) @(negedge clk);
        data = 8'hFF;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
      end
    join_none
    body(0, {1'b1, 8'h0F, 1'b0}, 10, 1'b0, "busy_ign");

    data = 8'h99;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (70) @(negedge clk);
    chk("mid_busy_pre", busy_v[0], 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_chk(0, "mid_rst");
    repeat (3) @(negedge clk);
    idle_chk(0, "mid_after");
    send(0, 8'h3C, {1'b1, 8'h3C, 1'b0}, 10, "n1_3c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
